// File: rtl/iter_control_pkg.sv
// Shared stage codes for the state controller and iter_control, plus the
// iteration FSM encoding.
package iter_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'b000,
    ST_GET_PARAM  = 3'b001,
    ST_DECODE     = 3'b010,
    ST_EX         = 3'b011,
    ST_MEM        = 3'b100,
    ST_WRITE_BACK = 3'b101,
    ST_DONE       = 3'b110
  } stage_e;

  typedef enum logic [1:0] {
    IT_IDLE = 2'd0,
    IT_RUN  = 2'd1,
    IT_FIN  = 2'd2
  } iter_fsm_e;

endpackage

// File: rtl/iter_control_addr_gen.sv
// Parameter address accumulator: load base/stride, then add stride per step,
// wrapping modulo 2^ADDR_W.
module addr_gen #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
    end else if (i_step) begin
      r_addr   <= r_addr + r_stride;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/iter_control.sv
// Iteration controller: walks cfg_count parameter reads driven by the stage
// codes of the state controller and flags the final WRITE_BACK.
module iter_control
  import iter_control_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        state,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              param_rd_en,
  output logic [ADDR_W-1:0] param_addr,
  output logic [CNT_W-1:0]  iter_idx,
  output logic              finish,
  output logic              busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  iter_fsm_e        r_fsm;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;
  logic             r_last;
  logic             r_busy;

  logic             w_run;
  logic             w_get;
  logic             w_wb;
  logic             w_start;
  logic             w_zero;
  logic             w_load;
  logic             w_step;
  logic [CNT_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_m1;

  assign w_run     = (r_fsm == IT_RUN);
  assign w_get     = (state == ST_GET_PARAM);
  assign w_wb      = (state == ST_WRITE_BACK);
  assign w_start   = (r_fsm == IT_IDLE) && start;
  assign w_zero    = (cfg_count == '0);
  assign w_load    = w_start && !w_zero;
  assign w_step    = w_run && w_wb && !r_last;
  assign w_idx_nxt = r_idx + ONE;
  assign w_cnt_m1  = r_count - ONE;

  addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_base   (cfg_base),
    .i_stride (cfg_stride),
    .i_step   (w_step),
    .o_addr   (param_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= IT_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_fsm)
        IT_IDLE: begin
          if (start) begin
            if (w_zero) begin
              r_fsm <= IT_FIN;
            end else begin
              r_fsm   <= IT_RUN;
              r_count <= cfg_count;
              r_idx   <= '0;
              r_last  <= (cfg_count == ONE);
              r_busy  <= 1'b1;
            end
          end
        end
        IT_RUN: begin
          if (w_wb) begin
            if (r_last) begin
              r_fsm  <= IT_FIN;
              r_busy <= 1'b0;
            end else begin
              // last tracks the index being entered, so it is ready at its WRITE_BACK
              r_idx  <= w_idx_nxt;
              r_last <= (w_idx_nxt == w_cnt_m1);
            end
          end
        end
        IT_FIN:  ;
        default: r_fsm <= IT_IDLE;
      endcase
    end
  end

  assign param_rd_en = w_run && w_get;
  assign finish      = !rst && ((w_start && w_zero) || (w_run && r_last && w_wb));
  assign iter_idx    = r_idx;
  assign busy        = r_busy;

endmodule

// File: tb/tb_iter_control.sv
// Self-checking bench for iter_control: vector table of traversals plus
// hand-written reset and re-start sequences, with an address scoreboard.
module tb_iter_control;
  import iter_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  state;
  logic [15:0] cfg_base;
  logic [15:0] cfg_stride;
  logic [11:0] cfg_count;
  logic        param_rd_en;
  logic [15:0] param_addr;
  logic [11:0] iter_idx;
  logic        finish;
  logic        busy;

  iter_control #(.ADDR_W(16), .CNT_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .state       (state),
    .cfg_base    (cfg_base),
    .cfg_stride  (cfg_stride),
    .cfg_count   (cfg_count),
    .param_rd_en (param_rd_en),
    .param_addr  (param_addr),
    .iter_idx    (iter_idx),
    .finish      (finish),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    logic [11:0] count;
    logic [15:0] exp_addr;
    logic [11:0] exp_idx;
    int          exp_reads;
    int          exp_fins;
  } vec_t;

  vec_t        vecs [5];
  int          checks = 0;
  int          errors = 0;
  int          reads  = 0;
  int          fins   = 0;
  logic [15:0] sb_q [$];

  // reference model: 0 idle, 1 run, 2 fin
  int          m_st;
  logic [15:0] m_addr;
  logic [15:0] m_stride;
  logic [11:0] m_idx;
  logic [11:0] m_cnt;
  logic        m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (param_rd_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual addr=%0h expected no read", param_addr);
      end else begin
        chk("rd_addr", {16'h0, param_addr}, {16'h0, sb_q.pop_front()});
      end
      reads++;
    end
  end

  // Called at posedge+1; drives, checks at posedge+3, advances to next posedge+1.
  task automatic step(input logic [2:0] st, input logic s, input logic [15:0] b,
                      input logic [15:0] sd, input logic [11:0] c, input logic r);
    logic exp_rd, exp_fin;
    rst = r; start = s; state = st; cfg_base = b; cfg_stride = sd; cfg_count = c;
    #2;
    exp_rd  = (m_st == 1) && (st == ST_GET_PARAM);
    exp_fin = !r && (((m_st == 0) && s && (c == 12'd0)) ||
                     ((m_st == 1) && m_last && (st == ST_WRITE_BACK)));
    if (exp_rd) sb_q.push_back(m_addr);
    chk("rd_en",    {31'h0, param_rd_en}, {31'h0, exp_rd});
    chk("finish",   {31'h0, finish},      {31'h0, exp_fin});
    chk("busy",     {31'h0, busy},        {31'h0, (m_st == 1)});
    chk("iter_idx", {20'h0, iter_idx},    {20'h0, m_idx});
    chk("addr",     {16'h0, param_addr},  {16'h0, m_addr});
    if (finish === 1'b1) fins++;
    if (r) begin
      m_st = 0; m_addr = '0; m_stride = '0; m_idx = '0; m_cnt = '0; m_last = 1'b0;
    end else if (m_st == 0) begin
      if (s) begin
        if (c == 12'd0) m_st = 2;
        else begin
          m_st = 1; m_addr = b; m_stride = sd; m_cnt = c; m_idx = '0; m_last = (c == 12'd1);
        end
      end
    end else if (m_st == 1 && st == ST_WRITE_BACK) begin
      if (m_last) m_st = 2;
      else begin
        m_idx  = m_idx + 12'd1;
        m_addr = m_addr + m_stride;
        m_last = (m_idx == m_cnt - 12'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [2:0] st);
    step(st, 1'b0, 16'h0, 16'h0, 12'h0, 1'b0);
  endtask

  // One controller pass; start re-pulsed with junk config during EX, plus a stray code.
  task automatic run_iter();
    drv(ST_GET_PARAM);
    drv(ST_DECODE);
    step(ST_EX, 1'b1, 16'hDEAD, 16'h0BAD, 12'h000, 1'b0);
    drv(ST_MEM);
    drv(3'b111);
    step(ST_EX, 1'b1, 16'h1111, 16'h2222, 12'h007, 1'b0);
    drv(ST_WRITE_BACK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0100, 16'h0004, 12'd3, 16'h0108, 12'd2, 3, 1};
    vecs[1] = '{16'hFFFC, 16'h0008, 12'd2, 16'h0004, 12'd1, 2, 1};
    vecs[2] = '{16'h1234, 16'h0010, 12'd1, 16'h1234, 12'd0, 1, 1};
    vecs[3] = '{16'h0200, 16'h0004, 12'd0, 16'h0000, 12'd0, 0, 1};
    vecs[4] = '{16'h0000, 16'hFFFF, 12'd4, 16'hFFFD, 12'd3, 4, 1};

    rst = 1'b1; start = 1'b0; state = ST_IDLE;
    cfg_base = '0; cfg_stride = '0; cfg_count = '0;
    m_st = 0; m_addr = '0; m_stride = '0; m_idx = '0; m_cnt = '0; m_last = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      step(ST_IDLE, 1'b0, 16'h0, 16'h0, 12'h0, 1'b1);
      reads = 0;
      fins  = 0;
      step(ST_IDLE, 1'b1, vecs[v].base, vecs[v].stride, vecs[v].count, 1'b0);
      for (int i = 0; i < int'(vecs[v].count); i++) run_iter();
      run_iter();
      run_iter();
      #3;
      chk("final_addr", {16'h0, param_addr}, {16'h0, vecs[v].exp_addr});
      chk("final_idx",  {20'h0, iter_idx},   {20'h0, vecs[v].exp_idx});
      chk("reads",      reads,               vecs[v].exp_reads);
      chk("fin_pulses", fins,                vecs[v].exp_fins);
      chk("fin_busy",   {31'h0, busy},       32'h0);
      chk("sb_empty",   sb_q.size(),         32'h0);
      @(posedge clk);
      #1;
    end

    // reset in the second EX of a count=5 run, then a count=1 run at a new base
    step(ST_IDLE, 1'b0, 16'h0, 16'h0, 12'h0, 1'b1);
    step(ST_IDLE, 1'b1, 16'h0300, 16'h0002, 12'd5, 1'b0);
    run_iter();
    drv(ST_GET_PARAM);
    drv(ST_DECODE);
    step(ST_EX, 1'b0, 16'h0, 16'h0, 12'h0, 1'b1);
    #2;
    chk("rst_rd_en",  {31'h0, param_rd_en}, 32'h0);
    chk("rst_addr",   {16'h0, param_addr},  32'h0);
    chk("rst_idx",    {20'h0, iter_idx},    32'h0);
    chk("rst_busy",   {31'h0, busy},        32'h0);
    chk("rst_finish", {31'h0, finish},      32'h0);
    @(posedge clk);
    #1;
    // rst beats a zero-count start in the same cycle
    step(ST_IDLE, 1'b1, 16'h0500, 16'h0001, 12'd0, 1'b1);
    reads = 0;
    fins  = 0;
    step(ST_IDLE, 1'b1, 16'h0800, 16'h0020, 12'd1, 1'b0);
    run_iter();
    run_iter();
    #3;
    chk("re_reads", reads,              32'd1);
    chk("re_fins",  fins,               32'd1);
    chk("re_addr",  {16'h0, param_addr}, 32'h0800);
    chk("re_idx",   {20'h0, iter_idx},  32'h0);
    chk("re_sb",    sb_q.size(),        32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
